// File: rtl/utopia_phy_tx_if.sv
// Write port and Utopia Level-1 receive-side bus between a cell source and the PHY transmitter.
interface utopia_phy_tx_if #(
    parameter int IfWidth = 8
);
    logic [IfWidth-1:0] wr_data;
    logic               wr_sop;
    logic               wr_valid;
    logic               wr_ready;
    logic               wr_err;
    logic               en;
    logic               clav;
    logic               soc;
    logic [IfWidth-1:0] data;
    logic [15:0]        cells_sent;

    modport slave (
        input  wr_data, wr_sop, wr_valid, en,
        output wr_ready, wr_err, clav, soc, data, cells_sent
    );

    modport master (
        output wr_data, wr_sop, wr_valid, en,
        input  wr_ready, wr_err, clav, soc, data, cells_sent
    );
endinterface

// File: rtl/utopia_phy_tx.sv
// PHY-side Utopia Level-1 cell transmitter with a multi-cell buffer loaded byte-wise.
// Define UTOPIA_PHY_TX_HEC_GEN_EN to replace byte 4 with a generated HEC on transmit.
module utopia_phy_tx #(
    parameter int IfWidth   = 8,
    parameter int CellBytes = 53,
    parameter int Depth     = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    utopia_phy_tx_if.slave   bus
);
    localparam int SW = $clog2(Depth);
    localparam int IW = $clog2(CellBytes);
    localparam int AW = $clog2(Depth * CellBytes);
    localparam int CW = SW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [IfWidth-1:0] mem [Depth*CellBytes];

    state_t             state_q;
    logic [IW-1:0]      wr_idx_q, rd_idx_q;
    logic [SW-1:0]      wr_slot_q, rd_slot_q;
    logic [CW-1:0]      slots_used_q, pend_q;
    logic               wr_ready_q, wr_err_q, clav_q, soc_q;
    logic [IfWidth-1:0] data_q;
    logic [15:0]        cells_sent_q;

    logic               accept, drop, resync, wr_en, commit, start, rel;
    logic [IW-1:0]      wr_pos, rd_pos;
    logic [AW-1:0]      wr_base, wr_addr, rd_addr;
    logic [CW-1:0]      slots_used_d, pend_d;
    logic [IfWidth-1:0] tx_byte;

    // A sop always restarts framing at byte 0; a missing sop at byte 0 drops the byte.
    assign accept  = bus.wr_valid & wr_ready_q;
    assign drop    = accept & ~bus.wr_sop & (wr_idx_q == '0);
    assign resync  = accept & bus.wr_sop & (wr_idx_q != '0);
    assign wr_en   = accept & ~drop;
    assign wr_pos  = bus.wr_sop ? '0 : wr_idx_q;
    assign commit  = wr_en & (wr_pos == IW'(CellBytes - 1));
    assign wr_base = AW'(wr_slot_q) * AW'(CellBytes);
    assign wr_addr = wr_base + AW'(wr_pos);

    assign start   = (state_q == IDLE) & ~bus.en & clav_q;
    assign rel     = (state_q == SEND) & ~bus.en & (rd_idx_q == IW'(CellBytes - 1));
    assign rd_pos  = start ? '0 : rd_idx_q;
    assign rd_addr = AW'(rd_slot_q) * AW'(CellBytes) + AW'(rd_pos);

    // Ready tracks the post-edge occupancy so a freed slot reopens the write port at once.
    assign slots_used_d = slots_used_q + CW'(commit) - CW'(rel);
    assign pend_d       = pend_q + CW'(commit) - CW'(start);

`ifdef UTOPIA_PHY_TX_HEC_GEN_EN
    logic [IfWidth-1:0] hec_q [Depth];

    function automatic logic [7:0] hec8(input logic [31:0] h);
        logic [7:0] c;
        c = '0;
        for (int b = 3; b >= 0; b--) begin
            c ^= h[b*8 +: 8];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c ^ 8'h55;
    endfunction

    assign tx_byte = (rd_pos == IW'(4)) ? hec_q[rd_slot_q] : mem[rd_addr];
`else
    assign tx_byte = mem[rd_addr];
`endif

    // Header bytes are already stored when byte 52 commits, so the HEC is latched then.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= bus.wr_data;
`ifdef UTOPIA_PHY_TX_HEC_GEN_EN
        if (commit)
            hec_q[wr_slot_q] <= hec8({mem[wr_base], mem[wr_base + AW'(1)],
                                      mem[wr_base + AW'(2)], mem[wr_base + AW'(3)]});
`endif
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            wr_slot_q    <= '0;
            rd_slot_q    <= '0;
            slots_used_q <= '0;
            pend_q       <= '0;
            wr_ready_q   <= 1'b0;
            wr_err_q     <= 1'b0;
            clav_q       <= 1'b0;
            soc_q        <= 1'b0;
            data_q       <= '0;
            cells_sent_q <= '0;
        end else begin
            wr_ready_q   <= slots_used_d < CW'(Depth);
            wr_err_q     <= drop | resync;
            slots_used_q <= slots_used_d;
            pend_q       <= pend_d;
            clav_q       <= pend_d != '0;
            if (wr_en) wr_idx_q <= commit ? '0 : wr_pos + IW'(1);
            if (commit) wr_slot_q <= wr_slot_q + SW'(1);

            case (state_q)
                IDLE: begin
                    soc_q <= 1'b0;
                    if (start) begin
                        data_q   <= tx_byte;
                        soc_q    <= 1'b1;
                        rd_idx_q <= IW'(1);
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    soc_q <= 1'b0;
                    if (!bus.en) begin
                        data_q <= tx_byte;
                        if (rel) begin
                            rd_idx_q     <= '0;
                            rd_slot_q    <= rd_slot_q + SW'(1);
                            cells_sent_q <= cells_sent_q + 16'd1;
                            state_q      <= IDLE;
                        end else begin
                            rd_idx_q <= rd_idx_q + IW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready   = wr_ready_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.clav       = clav_q;
    assign bus.soc        = soc_q;
    assign bus.data       = data_q;
    assign bus.cells_sent = cells_sent_q;
endmodule

// File: doc/utopia_phy_tx.md
Name: utopia_phy_tx

Overview:
- PHY-side Utopia Level-1 cell transmitter.
- It is the far end of the ATM-layer receive port: it drives `data`, `soc` and `clav`, and responds to the active-low `en` issued by the core receiver.
- Cells are loaded byte-wise through a local write port into a multi-cell buffer.
- A cell is offered on `clav` only once all 53 bytes are buffered.
- Used as synthesizable stimulus / PHY model on the receive side of the switch.

Parameters:
- IfWidth, 8, width of `data` and `wr_data` in bits (only 8 supported).
- CellBytes, 53, bytes per ATM cell (5 header + 48 payload).
- Depth, 4, buffer capacity in whole cells (power of 2, ≥2).

Ports:
- `clk_in`  input  1  Utopia clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `wr_data`  input  IfWidth  cell byte to load.
- `wr_sop`  input  1  marks byte 0 of a cell on the write port.
- `wr_valid`  input  1  `wr_data` valid this cycle.
- `wr_ready`  output  1  buffer can accept a byte.
- `wr_err`  output  1  one-cycle pulse on write framing error.
- `en`  input  1  Utopia enable from the receiver, active low.
- `clav`  output  1  at least one complete, unstarted cell available.
- `soc`  output  1  high while `data` carries byte 0 of a cell.
- `data`  output  IfWidth  cell byte to the receiver.
- `cells_sent`  output  16  count of fully transmitted cells; wraps 65535 to 0.

Behaviour:
- Reset (async assert): all outputs 0, including `wr_ready`. Write index, read index, slot counters and state are cleared; all buffered and partial cells are discarded. After deassertion, `wr_ready` = 1 from the first clock edge.
- Storage: Depth×CellBytes byte RAM organised as cell slots, with a write slot pointer and a read slot pointer (mod Depth).
- `slots_used` counts committed cells, including the cell currently being transmitted.
- Write path: a byte is accepted on an edge with `wr_valid` & `wr_ready`. `wr_ready` is registered and equals (`slots_used` < Depth).
- Write framing:
  - Byte 0 must carry `wr_sop`=1.
  - On byte index 52 the cell is committed: `slots_used`+1, write slot advances, index returns to 0.
- Write errors:
  - `wr_valid` without `wr_sop` at index 0: the byte is dropped and `wr_err` pulses.
  - `wr_sop` at index ≠ 0: the partial cell is discarded, `wr_err` pulses, and this byte is taken as byte 0 of a new cell.
- `clav`: registered; high when (committed cells not yet started) > 0 after the current edge's updates. A cell committed at edge N raises `clav` after edge N.
- Read FSM:
  - IDLE: on an edge with `en`=0 and `clav`=1, drive byte 0 on `data` with `soc`=1; idx=1; go to SEND. The unstarted-cell count drops by 1, so `clav` may fall on the same edge.
  - SEND, `en`=0: drive byte idx with `soc`=0. When idx=52: free the slot (`slots_used`−1), advance the read pointer, increment `cells_sent`, return to IDLE.
  - SEND, `en`=1: `data` holds the last byte, `soc`=0, idx holds.
  - IDLE, `en`=0 with `clav`=0: `data` and `soc` hold 0 / last value; no transfer starts.
- Latency: a byte appears on `data` the cycle after `en` is sampled low.
- Simultaneous commit and slot release on one edge: `slots_used` is unchanged and `wr_ready` stays 1.
- Full buffer: `wr_ready` rises on the edge after the last byte of a cell is transmitted.
- Reset mid-transfer: the transfer is aborted, no `cells_sent` increment, and `soc`/`data`/`clav` go to 0 immediately.

Optional Feature:
- Macro: `UTOPIA_PHY_TX_HEC_GEN_EN`.
- Defined:
  - HEC is computed over header bytes 0-3: CRC-8, polynomial x^8+x^2+x+1, init 0x00, result XOR 0x55.
  - The computed HEC replaces byte 4 on `data` at transmit time; the stored byte 4 is ignored.
  - Computation is registered at write commit and adds no transmit latency.
- Undefined: byte 4 is transmitted exactly as written.

Test Plan:
- Reset check: assert `reset` mid-cycle → `clav`/`soc`/`data`/`wr_ready`/`cells_sent`/`wr_err` = 0 asynchronously; `wr_ready`=1 after the first edge post-release.
- Single cell, bytes 0x00..0x34, `en` held low after `clav` → `soc`=1 only with 0x00; bytes arrive one per cycle, 0x00..0x34 in order; `clav`=0; `cells_sent`=1.
- `en` high for 3 cycles after byte 10 → `data` holds 0x0A, no `soc`; resumes with 0x0B; total of exactly 53 bytes.
- Load 4 cells (Depth=4) → `wr_ready`=0 after the 4th commit. Transmit one cell → `wr_ready`=1 on the edge after its last byte. A 5th cell then loads; `clav` stays 1 throughout.
- Framing errors:
  - `wr_sop` at byte 20 → `wr_err` single pulse; the new cell is transmitted intact and the old partial cell never appears.
  - `wr_valid` without `wr_sop` at index 0 → byte dropped, `wr_err` pulse.
- With `UTOPIA_PHY_TX_HEC_GEN_EN`, header 0x00,0x00,0x00,0x01 (byte 4 written as 0xFF) → byte 4 transmitted as 0x52. Without the macro → 0xFF.
